// File: rtl/id_queue.sv
// id_queue: registered instruction-decode queue sitting between fetch and execute.
// Each accepted MIPS word is decoded at push time. The decoded fields and the PC
// are stored together, so the head entry drives the outputs straight from storage.
//
// Optional feature macro: ID_BYPASS_EN. When it is defined, an empty queue hands
// an incoming instruction directly to a ready consumer in the same cycle.
//
// Parameters: DEPTH (power of two, >= 2), PC_W (carried PC width).
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   flush                 synchronous clear; takes priority over push and pop
//   in_valid/in_ready     fetch-side handshake
//   in_inst_code          32-bit instruction word
//   in_pc_addr            PC of that instruction
//   out_valid/out_ready   execute-side handshake
//   out_inst_type         INST_TYPE_R/I/J/INVALID
//   out_opcode .. out_jump_addr  decoded fields of the head entry
//   out_pc_addr           PC of the head entry
//   occupancy             number of stored entries

`ifndef INST_TYPE_INVALID
`define INST_TYPE_INVALID 2'b00
`endif
`ifndef INST_TYPE_R
`define INST_TYPE_R 2'b01
`endif
`ifndef INST_TYPE_I
`define INST_TYPE_I 2'b10
`endif
`ifndef INST_TYPE_J
`define INST_TYPE_J 2'b11
`endif

module id_queue #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst_code,
  input  logic [PC_W-1:0]          in_pc_addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_inst_type,
  output logic [5:0]               out_opcode,
  output logic [4:0]               out_reg_s,
  output logic [4:0]               out_reg_t,
  output logic [4:0]               out_reg_d,
  output logic [4:0]               out_shift,
  output logic [15:0]              out_immediate,
  output logic [31:0]              out_imm_ext,
  output logic [25:0]              out_jump_addr,
  output logic [PC_W-1:0]          out_pc_addr,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [1:0]      inst_type;
    logic [5:0]      opcode;
    logic [4:0]      reg_s;
    logic [4:0]      reg_t;
    logic [4:0]      reg_d;
    logic [4:0]      shift;
    logic [15:0]     immediate;
    logic [31:0]     imm_ext;
    logic [25:0]     jump_addr;
    logic [PC_W-1:0] pc_addr;
  } entry_t;

  // Opcode classification and field extraction. Unused fields stay zero so
  // that downstream logic never sees stale bits from the instruction word.
  function automatic entry_t decode(input logic [31:0] code, input logic [PC_W-1:0] pc);
    entry_t e;
    logic [5:0] op;
    logic is_r, is_j, is_cop0, is_i, zero_ext;
    op       = code[31:26];
    is_r     = (op == 6'b000000);
    is_j     = (op[5:1] == 5'b00001);
    is_cop0  = (op == 6'b010000);
    // 000001, 0001xx, 001xxx, COP0, and 10xxxx (loads/stores)
    is_i     = (op == 6'b000001) || (op[5:2] == 4'b0001) || (op[5:3] == 3'b001) ||
               is_cop0 || (op[5:4] == 2'b10);
    // andi / ori / xori take a zero-extended immediate
    zero_ext = (op == 6'b001100) || (op == 6'b001101) || (op == 6'b001110);

    e         = '0;
    e.opcode  = op;
    e.pc_addr = pc;
    if (is_r)      e.inst_type = `INST_TYPE_R;
    else if (is_j) e.inst_type = `INST_TYPE_J;
    else if (is_i) e.inst_type = `INST_TYPE_I;
    else           e.inst_type = `INST_TYPE_INVALID;

    if (is_r || is_i) begin
      e.reg_s = code[25:21];
      e.reg_t = code[20:16];
    end
    if (is_r || is_cop0) e.reg_d = code[15:11];
    if (is_r)            e.shift = code[10:6];
    if (is_i) begin
      e.immediate = code[15:0];
      e.imm_ext   = zero_ext ? {16'h0000, code[15:0]} : {{16{code[15]}}, code[15:0]};
    end
    if (is_j) e.jump_addr = code[25:0];
    return e;
  endfunction

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            bypass_hit;
  logic            push;
  logic            pop;
  entry_t          out_e;

  // Bypass only fires on an empty queue with a ready consumer, so nothing is stored.
`ifdef ID_BYPASS_EN
  assign bypass_hit = (count == '0) && !flush && in_valid && out_ready;
`else
  assign bypass_hit = 1'b0;
`endif

  // in_ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0) || bypass_hit;
  assign push      = in_valid && in_ready && !flush && !bypass_hit;
  assign pop       = (count != '0) && out_ready && !flush;
  assign occupancy = count;

  // Pointer and occupancy bookkeeping. Flush wins over both push and pop, and
  // DEPTH being a power of two lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Entry storage needs no reset: outputs are masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= decode(in_inst_code, in_pc_addr);
  end

  // Head selection: bypass data, stored head, or the idle pattern (zeros, INVALID).
  always_comb begin
    out_e           = '0;
    out_e.inst_type = `INST_TYPE_INVALID;
    if (bypass_hit)        out_e = decode(in_inst_code, in_pc_addr);
    else if (count != '0)  out_e = mem[rd_ptr];
  end

  assign out_inst_type = out_e.inst_type;
  assign out_opcode    = out_e.opcode;
  assign out_reg_s     = out_e.reg_s;
  assign out_reg_t     = out_e.reg_t;
  assign out_reg_d     = out_e.reg_d;
  assign out_shift     = out_e.shift;
  assign out_immediate = out_e.immediate;
  assign out_imm_ext   = out_e.imm_ext;
  assign out_jump_addr = out_e.jump_addr;
  assign out_pc_addr   = out_e.pc_addr;

endmodule

// File: tb/tb_id_queue.sv
// tb_id_queue: randomized scoreboard bench for id_queue.
// The stimulus process records each accepted instruction's expected decode in a
// queue. The monitor samples on the falling edge and compares the head against it.

`ifndef INST_TYPE_INVALID
`define INST_TYPE_INVALID 2'b00
`endif
`ifndef INST_TYPE_R
`define INST_TYPE_R 2'b01
`endif
`ifndef INST_TYPE_I
`define INST_TYPE_I 2'b10
`endif
`ifndef INST_TYPE_J
`define INST_TYPE_J 2'b11
`endif

module tb_id_queue;

  localparam int DEPTH = 2;
  localparam int PC_W  = 32;
`ifdef ID_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst_code;
  logic [31:0] in_pc_addr;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_inst_type;
  logic [5:0]  out_opcode;
  logic [4:0]  out_reg_s, out_reg_t, out_reg_d, out_shift;
  logic [15:0] out_immediate;
  logic [31:0] out_imm_ext;
  logic [25:0] out_jump_addr;
  logic [31:0] out_pc_addr;
  logic [$clog2(DEPTH):0] occupancy;

  id_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst_code(in_inst_code), .in_pc_addr(in_pc_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst_type(out_inst_type), .out_opcode(out_opcode),
    .out_reg_s(out_reg_s), .out_reg_t(out_reg_t), .out_reg_d(out_reg_d),
    .out_shift(out_shift), .out_immediate(out_immediate),
    .out_imm_ext(out_imm_ext), .out_jump_addr(out_jump_addr),
    .out_pc_addr(out_pc_addr), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  t;
    logic [5:0]  op;
    logic [4:0]  s, rt, d, sh;
    logic [15:0] imm;
    logic [31:0] ext;
    logic [25:0] jmp;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference decoder written from the opcode table rather than from bit patterns.
  function automatic exp_t refDecode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    int op;
    bit r, j, i, c0;
    op = int'(w[31:26]);
    r  = (op == 0);
    j  = (op == 2) || (op == 3);
    c0 = (op == 16);
    i  = (op == 1) || (op >= 4 && op <= 15) || c0 || (op >= 32 && op <= 47);
    e.t   = r ? `INST_TYPE_R : j ? `INST_TYPE_J : i ? `INST_TYPE_I : `INST_TYPE_INVALID;
    e.op  = w[31:26];
    e.pc  = pc;
    e.s   = (r || i) ? w[25:21] : 5'd0;
    e.rt  = (r || i) ? w[20:16] : 5'd0;
    e.d   = (r || c0) ? w[15:11] : 5'd0;
    e.sh  = r ? w[10:6] : 5'd0;
    e.imm = i ? w[15:0] : 16'd0;
    e.jmp = j ? w[25:0] : 26'd0;
    if (!i)                      e.ext = 32'd0;
    else if (op >= 12 && op <= 14) e.ext = {16'd0, w[15:0]};
    else                         e.ext = {{16{w[15]}}, w[15:0]};
    return e;
  endfunction

  function automatic exp_t idleExp();
    exp_t e;
    e.t = `INST_TYPE_INVALID; e.op = '0; e.s = '0; e.rt = '0; e.d = '0; e.sh = '0;
    e.imm = '0; e.ext = '0; e.jmp = '0; e.pc = '0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkFields(input string tag, input exp_t e);
    checkOutput({tag, "_type"},  32'(out_inst_type), 32'(e.t));
    checkOutput({tag, "_op"},    32'(out_opcode),    32'(e.op));
    checkOutput({tag, "_rs"},    32'(out_reg_s),     32'(e.s));
    checkOutput({tag, "_rt"},    32'(out_reg_t),     32'(e.rt));
    checkOutput({tag, "_rd"},    32'(out_reg_d),     32'(e.d));
    checkOutput({tag, "_shamt"}, 32'(out_shift),     32'(e.sh));
    checkOutput({tag, "_imm"},   32'(out_immediate), 32'(e.imm));
    checkOutput({tag, "_ext"},   out_imm_ext,        e.ext);
    checkOutput({tag, "_jmp"},   32'(out_jump_addr), 32'(e.jmp));
    checkOutput({tag, "_pc"},    out_pc_addr,        e.pc);
  endtask

  // Drive one cycle of inputs at posedge+2. At the next edge, record what the
  // queue should have accepted, using only the bench's own occupancy model.
  task automatic applyStimulus(input logic v, input logic [31:0] code, input logic [31:0] pc,
                               input logic rdy, input logic fl);
    int pre_cnt;
    #2;
    in_valid = v; in_inst_code = code; in_pc_addr = pc; out_ready = rdy; flush = fl;
    #2;
    pre_cnt = sb.size();
    @(posedge clk);
    if (fl) sb.delete();
    else if (v && pre_cnt != DEPTH && !(BYP && pre_cnt == 0 && rdy))
      sb.push_back(refDecode(code, pc));
  endtask

  task automatic idleCheckConst(input logic [1:0] t, input int s, input int rt, input int d,
                                input int sh, input logic [31:0] pc);
    #2;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #3;
    checkOutput("tp1_valid", 32'(out_valid), 32'd1);
    checkOutput("tp1_type",  32'(out_inst_type), 32'(t));
    checkOutput("tp1_rs",    32'(out_reg_s), 32'(s));
    checkOutput("tp1_rt",    32'(out_reg_t), 32'(rt));
    checkOutput("tp1_rd",    32'(out_reg_d), 32'(d));
    checkOutput("tp1_shamt", 32'(out_shift), 32'(sh));
    checkOutput("tp1_pc",    out_pc_addr, pc);
    @(posedge clk);
  endtask

  // Monitor: the expected head comes from the scoreboard, or from the live
  // input when a bypass is expected. Entries are retired on a modelled pop.
  int   mon_cnt;
  bit   mon_byp, mon_valid;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      mon_cnt   = sb.size();
      mon_byp   = BYP && mon_cnt == 0 && !flush && in_valid && out_ready;
      mon_valid = (mon_cnt != 0) || mon_byp;
      checkOutput("occupancy", 32'(occupancy), 32'(mon_cnt));
      checkOutput("in_ready",  32'(in_ready),  32'(mon_cnt != DEPTH));
      checkOutput("out_valid", 32'(out_valid), 32'(mon_valid));
      if (mon_byp)            mon_e = refDecode(in_inst_code, in_pc_addr);
      else if (mon_cnt != 0)  mon_e = sb[0];
      else                    mon_e = idleExp();
      checkFields("head", mon_e);
      if (mon_cnt != 0 && out_ready && !flush) void'(sb.pop_front());
    end
  end

  logic [31:0] rnd_word;
  logic [31:0] words[6] = '{32'h012A4020, 32'h2108FFFF, 32'h3508FFFF,
                            32'h0C100004, 32'hFC000000, 32'h4080_6000};

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst_code = '0; in_pc_addr = '0;
    #3;
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_occ",   32'(occupancy), 32'd0);
    checkOutput("rst_ready", 32'(in_ready),  32'd1);
    checkOutput("rst_type",  32'(out_inst_type), 32'(`INST_TYPE_INVALID));
    checkOutput("rst_pc",    out_pc_addr, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);

    // R-type word held at the head with the consumer stalled
    applyStimulus(1'b1, 32'h012A4020, 32'h00400000, 1'b0, 1'b0);
    idleCheckConst(`INST_TYPE_R, 9, 10, 8, 0, 32'h00400000);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Directed table streamed through with the consumer ready
    foreach (words[k]) applyStimulus(1'b1, words[k], 32'h00400100 + 32'(k * 4), 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill past capacity while stalled, then drain in order
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, words[k], 32'h00500000 + 32'(k * 4), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush a full queue with a simultaneous push
    for (int k = 0; k < 2; k++) applyStimulus(1'b1, words[k + 1], 32'h00600000 + 32'(k * 4), 1'b0, 1'b0);
    applyStimulus(1'b1, words[3], 32'h00600010, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Asynchronous reset in mid-cycle while one entry is held
    applyStimulus(1'b1, words[5], 32'h00700000, 1'b0, 1'b0);
    #2;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #5 rst = 1'b1;
    #1;
    checkOutput("arst_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_occ",   32'(occupancy), 32'd0);
    sb.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    applyStimulus(1'b1, words[0], 32'h00700040, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      rnd_word = $urandom();
      applyStimulus(1'($urandom_range(0, 9) < 7), rnd_word, $urandom(),
                    1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0));
    end
    for (int k = 0; k < DEPTH + 1; k++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_queue.md
Name: id_queue

Overview:
- Next-generation instruction-decode stage: a registered, parametrised-depth decode queue between fetch and execute.
- Each accepted 32-bit MIPS instruction word is decoded into type, register fields, immediates and jump target, then stored with its PC.
- Valid/ready handshakes on both sides plus a synchronous flush for branch redirects and exceptions.
- Replaces purely combinational decode with back-pressure tolerance and a one-cycle registered boundary.

Parameters:
- DEPTH, 2, queue entries; power of two, at least 2.
- PC_W, 32, width of the carried PC.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  synchronous queue clear.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  queue can accept.
- in_inst_code  in  32  instruction word.
- in_pc_addr  in  PC_W  PC of the instruction.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head.
- out_inst_type  out  2  `INST_TYPE_R/I/J/INVALID from defs.v.
- out_opcode  out  6  bits [31:26].
- out_reg_s  out  5  rs.
- out_reg_t  out  5  rt.
- out_reg_d  out  5  rd.
- out_shift  out  5  shamt.
- out_immediate  out  16  raw imm16.
- out_imm_ext  out  32  extended immediate.
- out_jump_addr  out  26  J target field.
- out_pc_addr  out  PC_W  PC of head.
- occupancy  out  $clog2(DEPTH)+1  entries held.

Behaviour:
- Reset (rst=1, async): queue emptied, pointers and occupancy 0, out_valid 0, all data outputs 0, out_inst_type `INST_TYPE_INVALID. Reset asserted mid-operation discards all entries immediately.
- Push happens when in_valid && in_ready. in_ready = (occupancy != DEPTH), derived from registered state only, with no combinational path from out_ready.
- Pop happens when out_valid && out_ready. out_valid = (occupancy != 0).
- Push and pop in the same cycle: occupancy unchanged. This is legal at any non-full occupancy; when full, in_ready is 0, so no push occurs.
- Pointers wrap modulo DEPTH.
- Latency: an instruction accepted in cycle N appears at the head no earlier than cycle N+1.
- Decode is performed at push and stored in the entry.
- Classification by opcode:
  - 000000 -> R.
  - 000010, 000011 -> J.
  - 000001, 0001xx, 001xxx, 010000 (COP0), 100xxx, 101xxx -> I.
  - All other opcodes -> INVALID.
- Field rules:
  - reg_s/reg_t = [25:21]/[20:16] for R and I, else 0.
  - reg_d = [15:11] for R and COP0, else 0.
  - shift = [10:6] for R only.
  - immediate = [15:0] for I only.
  - imm_ext: zero-extended for opcodes 001100, 001101, 001110; sign-extended for other I; 0 otherwise.
  - jump_addr = [25:0] for J only.
  - INVALID entries: only opcode and pc are kept, all other fields 0.
- Outputs are driven from the head entry. While out_valid=0, all data outputs read 0 and type reads INVALID.
- Flush=1: at the next edge the queue empties. A simultaneous push is dropped, and a simultaneous pop is irrelevant. Flush takes priority over push and pop.
- Head data is stable while out_valid=1 and out_ready=0.

Optional Feature:
- ID_BYPASS_EN:
  - When defined: if the queue is empty, flush=0, in_valid=1 and out_ready=1, the input is decoded combinationally and presented on the outputs in the same cycle with out_valid=1. It is consumed without being stored, and occupancy stays 0.
  - If out_ready=0 in that case, the input is stored normally.
  - When undefined: minimum latency is always 1 cycle and outputs are purely registered.

Test Plan:
- Push 0x012A4020 with pc 0x00400000 and out_ready=1 -> next cycle out_valid=1, type R, s=9, t=10, d=8, shift=0, pc 0x00400000. With ID_BYPASS_EN defined, the same values appear in the same cycle.
- Push 0x2108FFFF then 0x3508FFFF -> both type I; imm_ext 0xFFFFFFFF then 0x0000FFFF; immediate 0xFFFF both; reg_d 0.
- Push 0x0C100004 then 0xFC000000 -> first: J, jump_addr 0x0100004, other fields 0. Second: INVALID, opcode 0x3F, other fields 0.
- DEPTH=2, out_ready=0, in_valid=1 for 4 cycles -> occupancy 1, 2, 2, 2; in_ready 0 after the second push. Raise out_ready -> entries drain in order; occupancy 1 then 0.
- Queue holding 2 entries, flush=1 with in_valid=1 -> next cycle occupancy 0, out_valid 0, outputs 0/INVALID, pushed word absent.
- rst pulsed asynchronously mid-cycle with 1 entry held -> out_valid and occupancy drop to 0 without a clock edge; first push after release appears normally.
